// File: rtl/led_sweeper.sv
// led_sweeper
//
// Moves a single lit LED across a WIDTH-bit output. The pattern can bounce
// between the ends, rotate toward the MSB, rotate toward the LSB, or hold.
// A prescaler sets how often a step happens. When i_en is low, all state is frozen.
//
// Mode table (i_mode value | meaning):
//   MODE_BOUNCE 00 | walk to one end, reverse, and never repeat an end position
//   MODE_ROL    01 | step toward MSB, WIDTH-1 wraps to 0
//   MODE_ROR    10 | step toward LSB, 0 wraps to WIDTH-1
//   MODE_HOLD   11 | ticks are consumed, position and direction are kept
//
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_en     1 = prescaler runs and steps occur, 0 = freeze all state
//   i_mode   pattern mode (see table)
//   i_div    a step happens every i_div+1 enabled cycles
//   o_led    one-hot LED vector, registered
//   o_pos    index of the lit LED, registered
//   o_dir    0 = moving toward MSB, 1 = moving toward LSB, registered
//   o_wrap   one-cycle pulse after an end-of-sweep step, registered

module led_sweeper #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    output logic [WIDTH-1:0] o_led,
    output logic [PW-1:0]    o_pos,
    output logic             o_dir,
    output logic             o_wrap
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROL    = 2'b01,
        MODE_ROR    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_ONE = PW'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             tick;
    logic             move_up;
    mode_e            mode;

    assign mode = mode_e'(i_mode);

    // Using >= means that if i_div is lowered below the running count,
    // the next enabled cycle ticks. The prescaler does not wait for a wrap.
    assign tick = i_en && (cnt_q >= i_div);

    always_comb begin
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        move_up = 1'b0;

        if (tick) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (tick) begin
            case (mode)
                MODE_BOUNCE: begin
                    // If dir points outward at an end, the move reverses here.
                    move_up = (!dir_q && (pos_q != POS_MAX)) || (dir_q && (pos_q == '0));
                    pos_d   = move_up ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    if (pos_d == POS_MAX) begin
                        dir_d = 1'b1;
                    end else if (pos_d == '0) begin
                        dir_d = 1'b0;
                    end else begin
                        dir_d = !move_up;
                    end
                    wrap_d = (pos_d == POS_MAX) || (pos_d == '0);
                end
                MODE_ROL: begin
                    pos_d  = (pos_q == POS_MAX) ? '0 : (pos_q + POS_ONE);
                    dir_d  = 1'b0;
                    wrap_d = (pos_q == POS_MAX);
                end
                MODE_ROR: begin
                    pos_d  = (pos_q == '0) ? POS_MAX : (pos_q - POS_ONE);
                    dir_d  = 1'b1;
                    wrap_d = (pos_q == '0);
                end
                default: begin
                end
            endcase
        end

        led_d = WIDTH'(1) << pos_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            led_q  <= WIDTH'(1);
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    assign o_led  = led_q;
    assign o_pos  = pos_q;
    assign o_dir  = dir_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_sweeper.sv
module tb_led_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        rst8  = 1'b1;
    logic        en8   = 1'b0;
    logic [1:0]  mode8 = 2'b00;
    logic [23:0] div8  = 24'd0;
    logic [7:0]  led8;
    logic [2:0]  pos8;
    logic        dir8, wrap8;

    // WIDTH=5 instance
    logic        rst5  = 1'b1;
    logic        en5   = 1'b0;
    logic [1:0]  mode5 = 2'b00;
    logic [7:0]  div5  = 8'd0;
    logic [4:0]  led5;
    logic [2:0]  pos5;
    logic        dir5, wrap5;

    int n_checks = 0;
    int n_pass   = 0;

    int m8_cnt = 0, m8_pos = 0;
    bit m8_dir = 1'b0, m8_wrap = 1'b0;
    int m5_cnt = 0, m5_pos = 0;
    bit m5_dir = 1'b0, m5_wrap = 1'b0;

    led_sweeper #(.WIDTH(8), .DIV_W(24)) dut8 (
        .i_clk(clk), .i_reset(rst8), .i_en(en8), .i_mode(mode8), .i_div(div8),
        .o_led(led8), .o_pos(pos8), .o_dir(dir8), .o_wrap(wrap8)
    );

    led_sweeper #(.WIDTH(5), .DIV_W(8)) dut5 (
        .i_clk(clk), .i_reset(rst5), .i_en(en5), .i_mode(mode5), .i_div(div5),
        .o_led(led5), .o_pos(pos5), .o_dir(dir5), .o_wrap(wrap5)
    );

    always @(negedge clk) begin
        assert ($onehot(led8) && $onehot(led5))
        else $error("FAIL onehot: led8=%h led5=%h", led8, led5);
    end

    // Reference model. A bounce is treated as a walk around a ring of
    // 2*(w-1) phases. Phase p maps to position p on the way up and
    // to 2*(w-1)-p on the way down.
    task automatic model_step(input int w, input bit rst, input bit en, input int mode,
                              input int div, inout int cnt, inout int pos,
                              inout bit dir, output bit wrap);
        int ring, ph, np;
        wrap = 1'b0;
        if (rst) begin
            cnt = 0; pos = 0; dir = 1'b0;
        end else if (en) begin
            if (cnt >= div) begin
                cnt = 0;
                ring = 2 * (w - 1);
                case (mode)
                    0: begin
                        ph   = dir ? ((ring - pos) % ring) : pos;
                        np   = (ph + 1) % ring;
                        pos  = (np < w) ? np : ring - np;
                        dir  = (np >= w - 1);
                        wrap = (pos == 0) || (pos == w - 1);
                    end
                    1: begin
                        pos  = (pos + 1) % w;
                        dir  = 1'b0;
                        wrap = (pos == 0);
                    end
                    2: begin
                        pos  = (pos + w - 1) % w;
                        dir  = 1'b1;
                        wrap = (pos == w - 1);
                    end
                    default: ;
                endcase
            end else begin
                cnt = cnt + 1;
            end
        end
    endtask

    task automatic cycle8(input bit rst, input bit en, input int mode, input int div);
        rst8 = rst; en8 = en; mode8 = 2'(mode); div8 = 24'(div);
        @(posedge clk);
        model_step(8, rst, en, mode, div, m8_cnt, m8_pos, m8_dir, m8_wrap);
        @(negedge clk);
    endtask

    task automatic cycle5(input bit rst, input bit en, input int mode, input int div);
        rst5 = rst; en5 = en; mode5 = 2'(mode); div5 = 8'(div);
        @(posedge clk);
        model_step(5, rst, en, mode, div, m5_cnt, m5_pos, m5_dir, m5_wrap);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle8(1, 1, 0, 0);
        cycle8(1, 1, 1, 0);
        n_checks++;
        if ({led8, pos8, dir8, wrap8} !== {8'h01, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset: led=%h pos=%0d dir=%b wrap=%b, expected led=01 pos=0 dir=0 wrap=0",
                     led8, pos8, dir8, wrap8);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int e;
        cycle8(1, 1, 0, 0);
        for (int t = 1; t <= 15; t++) begin
            cycle8(0, 1, 0, 0);
            e = (t <= 7) ? t : ((t <= 14) ? 14 - t : t - 14);
            n_checks++;
            if ({pos8, dir8, wrap8} !== {3'(e), (t >= 7 && t <= 13), (t == 7 || t == 14)})
                $display("FAIL bounce t=%0d: pos=%0d dir=%b wrap=%b, expected pos=%0d dir=%b wrap=%b",
                         t, pos8, dir8, wrap8, e, (t >= 7 && t <= 13), (t == 7 || t == 14));
            else n_pass++;
            n_checks++;
            if ({led8, pos8, dir8, wrap8} !== {8'(1 << m8_pos), 3'(m8_pos), m8_dir, m8_wrap})
                $display("FAIL bounce_model t=%0d: got %h, expected %h", t,
                         {led8, pos8, dir8, wrap8}, {8'(1 << m8_pos), 3'(m8_pos), m8_dir, m8_wrap});
            else n_pass++;
        end
    endtask

    task automatic test_rotate_left();
        int wraps = 0;
        int e;
        cycle8(1, 1, 1, 3);
        for (int t = 1; t <= 40; t++) begin
            cycle8(0, 1, 1, 3);
            e = (t / 4) % 8;
            if (wrap8) wraps++;
            n_checks++;
            if ({led8, wrap8} !== {8'(1 << e), (t == 32)})
                $display("FAIL rotl t=%0d: led=%h wrap=%b, expected led=%h wrap=%b",
                         t, led8, wrap8, 8'(1 << e), (t == 32));
            else n_pass++;
        end
        n_checks++;
        if (wraps !== 1)
            $display("FAIL rotl_wrap_count: got %0d, expected 1", wraps);
        else n_pass++;
    endtask

    task automatic test_rotate_right();
        int e;
        cycle8(1, 1, 2, 0);
        for (int t = 1; t <= 9; t++) begin
            cycle8(0, 1, 2, 0);
            e = (8 - (t % 8)) % 8;
            n_checks++;
            if ({pos8, dir8, wrap8} !== {3'(e), 1'b1, (t == 1 || t == 9)})
                $display("FAIL rotr t=%0d: pos=%0d dir=%b wrap=%b, expected pos=%0d dir=1 wrap=%b",
                         t, pos8, dir8, wrap8, e, (t == 1 || t == 9));
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        cycle8(1, 1, 0, 0);
        for (int t = 0; t < 3; t++) cycle8(0, 1, 0, 0);
        n_checks++;
        if ({pos8, dir8} !== {3'd3, 1'b0})
            $display("FAIL pause_setup: pos=%0d dir=%b, expected pos=3 dir=0", pos8, dir8);
        else n_pass++;
        for (int t = 0; t < 15; t++) begin
            if (t < 10) cycle8(0, 0, 0, 0);
            else        cycle8(0, 1, 3, 0);
            n_checks++;
            if ({led8, pos8, wrap8} !== {8'h08, 3'd3, 1'b0})
                $display("FAIL pause t=%0d: led=%h pos=%0d wrap=%b, expected led=08 pos=3 wrap=0",
                         t, led8, pos8, wrap8);
            else n_pass++;
        end
        cycle8(0, 1, 0, 0);
        n_checks++;
        if ({pos8, dir8, wrap8} !== {3'd4, 1'b0, 1'b0} || m8_pos != 4)
            $display("FAIL pause_resume: pos=%0d dir=%b wrap=%b, expected pos=4 dir=0 wrap=0",
                     pos8, dir8, wrap8);
        else n_pass++;
    endtask

    task automatic test_div_change();
        cycle8(1, 1, 1, 100);
        for (int t = 0; t < 50; t++) cycle8(0, 1, 1, 100);
        n_checks++;
        if (pos8 !== 3'd0)
            $display("FAIL div_hold: pos=%0d, expected 0", pos8);
        else n_pass++;
        cycle8(0, 1, 1, 10);
        n_checks++;
        if (pos8 !== 3'd1)
            $display("FAIL div_lower: pos=%0d, expected 1", pos8);
        else n_pass++;
        for (int k = 1; k <= 11; k++) begin
            cycle8(0, 1, 1, 10);
            n_checks++;
            if (pos8 !== ((k == 11) ? 3'd2 : 3'd1))
                $display("FAIL div_period k=%0d: pos=%0d, expected %0d", k, pos8, (k == 11) ? 2 : 1);
            else n_pass++;
        end
        for (int k = 0; k < 5; k++) cycle8(0, 1, 1, 10);
        cycle8(1, 1, 1, 10);
        n_checks++;
        if ({led8, pos8, dir8, wrap8} !== {8'h01, 3'd0, 1'b0, 1'b0})
            $display("FAIL mid_reset: led=%h pos=%0d dir=%b wrap=%b, expected led=01 pos=0 dir=0 wrap=0",
                     led8, pos8, dir8, wrap8);
        else n_pass++;
        for (int k = 1; k <= 11; k++) begin
            cycle8(0, 1, 1, 10);
            n_checks++;
            if ({pos8, wrap8} !== {((k == 11) ? 3'd1 : 3'd0), 1'b0})
                $display("FAIL first_step k=%0d: pos=%0d wrap=%b, expected pos=%0d wrap=0",
                         k, pos8, wrap8, (k == 11) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit r, e;
        int m, d;
        cycle8(1, 1, 0, 0);
        for (int t = 0; t < 400; t++) begin
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            cycle8(r, e, m, d);
            n_checks++;
            if ({led8, pos8, dir8, wrap8} !== {8'(1 << m8_pos), 3'(m8_pos), m8_dir, m8_wrap})
                $display("FAIL random t=%0d: got %h, expected %h", t,
                         {led8, pos8, dir8, wrap8}, {8'(1 << m8_pos), 3'(m8_pos), m8_dir, m8_wrap});
            else n_pass++;
        end
    endtask

    task automatic test_width5();
        cycle5(1, 1, 1, 0);
        for (int t = 1; t <= 12; t++) begin
            cycle5(0, 1, 1, 0);
            n_checks++;
            if ({led5, pos5, wrap5} !== {5'(1 << (t % 5)), 3'(t % 5), (t % 5 == 0)})
                $display("FAIL w5_rotl t=%0d: led=%h pos=%0d wrap=%b, expected led=%h pos=%0d wrap=%b",
                         t, led5, pos5, wrap5, 5'(1 << (t % 5)), t % 5, (t % 5 == 0));
            else n_pass++;
        end
        for (int t = 0; t < 200; t++) begin
            cycle5(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 3), $urandom_range(0, 2));
            n_checks++;
            if ({led5, pos5, dir5, wrap5} !== {5'(1 << m5_pos), 3'(m5_pos), m5_dir, m5_wrap})
                $display("FAIL w5_random t=%0d: got %h, expected %h", t,
                         {led5, pos5, dir5, wrap5}, {5'(1 << m5_pos), 3'(m5_pos), m5_dir, m5_wrap});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_rotate_left();
        test_rotate_right();
        test_pause();
        test_div_change();
        test_random();
        test_width5();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
